param_writer: RTL and testbench
===============================

PARAM_WRITER -- requirements
Module: param_writer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, meaning clock cycles per serial bit; legal range 4..4095.
REQ-002 SHALL have port clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port serial_in  input  1  diagnostic config line; idles high; asynchronous to clock.
REQ-005 SHALL have port time_param_sel  output  2  parameter index of the last accepted write.
REQ-006 SHALL have port time_value  output  4  parameter value of the last accepted write.
REQ-007 SHALL have port reprogram  output  1  one-cycle write strobe to the time-parameter store.
REQ-008 SHALL have port frame_error  output  1  one-cycle pulse on a rejected frame.
REQ-009 SHALL have port busy  output  1  high from start-bit qualification until return to IDLE.

Function
REQ-010 SHALL pass serial_in through a 2-flop synchronizer; all decoding uses the synchronized value.
REQ-011 SHALL frame data as: start bit 0, 8 data bits LSB first, [PARITY_EN: one even-parity bit], stop bit 1.
REQ-012 SHALL decode the data byte as bits[3:0] = value, bits[5:4] = sel, bits[7:6] = command; only command 2'b10 (write) is legal.
REQ-013 SHALL use states IDLE, START, DATA, PARITY (only with PARITY_EN), STOP.
REQ-014 IDLE -> START SHALL occur only on a synchronized high-to-low transition, so a line held low never re-triggers.
REQ-015 START SHALL sample after CLKS_PER_BIT/2 cycles: low -> DATA; high -> IDLE as a false start, with no frame_error.
REQ-016 DATA SHALL sample every CLKS_PER_BIT cycles at mid-bit, shifting in 8 bits with a 3-bit index, then go to PARITY or STOP.
REQ-017 STOP SHALL sample mid-bit and then return to IDLE.
REQ-018 A frame SHALL be accepted only if all hold: stop = 1, command = 2'b10, and [PARITY_EN] parity correct.
REQ-019 On acceptance: time_param_sel/time_value SHALL update, and reprogram SHALL be high for exactly one cycle, both in the cycle after the stop sample.
REQ-020 On rejection: frame_error SHALL be high for exactly one cycle after the stop sample; time_param_sel/time_value SHALL hold; reprogram SHALL stay 0.
REQ-021 reprogram and frame_error SHALL never be high in the same cycle.
REQ-022 Value 0 and every sel (0..3) SHALL be accepted unfiltered; range checks belong to the parameter store.
REQ-023 The bit counter SHALL reload on every state transition; it SHALL count 0..CLKS_PER_BIT-1 and never wrap mid-bit.
REQ-024 A falling edge arriving while busy SHALL be ignored; the frame in progress continues.

Reset
REQ-025 Reset SHALL force: state IDLE, synchronizer flops 1, shift register 0, counters 0, time_param_sel 0, time_value 0, reprogram 0, frame_error 0, busy 0.
REQ-026 Reset mid-frame SHALL discard the partial frame with no strobe or error pulse; decoding restarts on the next falling edge after reset deasserts.

Configuration
REQ-027 Macro PARAM_WRITER_PARITY_EN SHALL select parity handling.
REQ-028 With PARAM_WRITER_PARITY_EN defined: the frame includes an even-parity bit after data, and a parity mismatch rejects the frame.
REQ-029 Without PARAM_WRITER_PARITY_EN: there is no PARITY state, and the frame is 10 bits.

Structure
REQ-030 Package param_writer_pkg SHALL hold the state enum, CMD_WRITE = 2'b10, DATA_BITS = 8, and the field bit positions.
REQ-031 Sub-module sync_2ff SHALL implement the input synchronizer; the FSM, counters and output registers stay in param_writer.

Verification (CLKS_PER_BIT=16, no parity unless stated)
REQ-032 Frame 0x9A -> reprogram single pulse, time_param_sel=2'b01, time_value=4'hA, frame_error=0.
REQ-033 Frame 0x5A (command 01) -> frame_error single pulse; outputs keep their prior values; no reprogram.
REQ-034 Frame 0xB3 with stop bit 0, line then held low 40 cycles -> one frame_error; no further frame decoded until the line goes high and falls again.
REQ-035 Low glitch of 4 cycles on an idle line -> busy pulses, returns to IDLE; no reprogram, no frame_error.
REQ-036 reset asserted during data bit 4 of frame 0x9A -> all outputs 0; a following clean frame 0xAF -> sel=2'b10, value=4'hF.
REQ-037 With PARAM_WRITER_PARITY_EN: 0x9A with parity 0 -> accepted; 0x9A with parity 1 -> frame_error, no reprogram.

Source files
------------

// File: rtl/param_writer_pkg.sv
// param_writer_pkg: shared types and constants for the serial parameter writer.
// Latency: n/a (definitions only). Backpressure: n/a.
// Contents: FSM state enum, frame field positions, write-command code and a
// decode helper. The PARITY state exists only when PARAM_WRITER_PARITY_EN is defined.
package param_writer_pkg;

    localparam int DATA_BITS = 8;
    localparam int IDX_W     = $clog2(DATA_BITS);

    // Data byte layout: [7:6] command, [5:4] parameter select, [3:0] value
    localparam int VAL_LSB = 0;
    localparam int VAL_MSB = 3;
    localparam int SEL_LSB = 4;
    localparam int SEL_MSB = 5;
    localparam int CMD_LSB = 6;
    localparam int CMD_MSB = 7;

    localparam logic [1:0] CMD_WRITE = 2'b10;

`ifdef PARAM_WRITER_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3
    } state_t;
`endif

    function automatic logic is_write(input logic [DATA_BITS-1:0] b);
        return b[CMD_MSB:CMD_LSB] == CMD_WRITE;
    endfunction

    function automatic logic [1:0] field_sel(input logic [DATA_BITS-1:0] b);
        return b[SEL_MSB:SEL_LSB];
    endfunction

    function automatic logic [3:0] field_val(input logic [DATA_BITS-1:0] b);
        return b[VAL_MSB:VAL_LSB];
    endfunction

endpackage

// File: rtl/param_writer_sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous level signal.
// Latency: 2 clock cycles from d to q. Backpressure: none.
// Ports: clock, reset (async active-high, flops load RESET_VAL), d (async in), q (synchronized out).
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/param_writer.sv
// param_writer: decodes framed serial writes into time-parameter store updates.
// Latency: reprogram/frame_error asserted the cycle after the stop-bit sample. Backpressure: none (fire-and-forget strobe).
// Ports: clock, reset (async active-high), serial_in (async, idles high);
//        time_param_sel/time_value (last accepted write), reprogram (1-cycle strobe),
//        frame_error (1-cycle reject pulse), busy (frame in progress).
// Build option: define PARAM_WRITER_PARITY_EN to add an even-parity bit after the data bits.
module param_writer
    import param_writer_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       serial_in,
    output logic [1:0] time_param_sel,
    output logic [3:0] time_value,
    output logic       reprogram,
    output logic       frame_error,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic rx;
    logic rx_prev_q;
    logic fall;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [1:0]             sel_q, sel_d;
    logic [3:0]             val_q, val_d;
    logic                   reprogram_q, reprogram_d;
    logic                   frame_error_q, frame_error_d;
    logic                   accept;
`ifdef PARAM_WRITER_PARITY_EN
    logic                   parity_bad_q, parity_bad_d;
`endif

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (serial_in),
        .q     (rx)
    );

    // Edge detect on the synchronized line: a line held low produces no edge,
    // and a line still low when reset releases looks like a fresh start.
    assign fall = rx_prev_q & ~rx;

`ifdef PARAM_WRITER_PARITY_EN
    assign accept = rx & is_write(shift_q) & ~parity_bad_q;
`else
    assign accept = rx & is_write(shift_q);
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q + CNT_W'(1);
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        sel_d         = sel_q;
        val_d         = val_q;
        reprogram_d   = 1'b0;
        frame_error_d = 1'b0;
`ifdef PARAM_WRITER_PARITY_EN
        parity_bad_d  = parity_bad_q;
`endif

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (fall) begin
                    state_d = START;
                end
            end

            START: begin
                // Half-bit wait lands subsequent samples in mid-bit.
                if (cnt_q == CNT_HALF) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx ? IDLE : DATA;
                end
            end

            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rx, shift_q[DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + IDX_W'(1);
                    if (bit_idx_q == IDX_LAST) begin
`ifdef PARAM_WRITER_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end

`ifdef PARAM_WRITER_PARITY_EN
            PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d        = '0;
                    // Even parity: data ones plus parity bit must be even.
                    parity_bad_d = rx ^ (^shift_q);
                    state_d      = STOP;
                end
            end
`endif

            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (accept) begin
                        sel_d       = field_sel(shift_q);
                        val_d       = field_val(shift_q);
                        reprogram_d = 1'b1;
                    end else begin
                        frame_error_d = 1'b1;
                    end
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_prev_q     <= 1'b1;
            state_q       <= IDLE;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            sel_q         <= '0;
            val_q         <= '0;
            reprogram_q   <= 1'b0;
            frame_error_q <= 1'b0;
`ifdef PARAM_WRITER_PARITY_EN
            parity_bad_q  <= 1'b0;
`endif
        end else begin
            rx_prev_q     <= rx;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            sel_q         <= sel_d;
            val_q         <= val_d;
            reprogram_q   <= reprogram_d;
            frame_error_q <= frame_error_d;
`ifdef PARAM_WRITER_PARITY_EN
            parity_bad_q  <= parity_bad_d;
`endif
        end
    end

    assign time_param_sel = sel_q;
    assign time_value     = val_q;
    assign reprogram      = reprogram_q;
    assign frame_error    = frame_error_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_param_writer.sv
// tb_param_writer: directed self-checking bench for param_writer (CLKS_PER_BIT = 16).
// Latency: n/a. Backpressure: n/a.
// Pulse monitors count reprogram/frame_error rising edges, over-width pulses and overlap.
module tb_param_writer;

    localparam int CPB = 16;

    logic       clock;
    logic       reset;
    logic       serial_in;
    logic [1:0] time_param_sel;
    logic [3:0] time_value;
    logic       reprogram;
    logic       frame_error;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    int  rp_cnt   = 0;
    int  fe_cnt   = 0;
    int  rp_wide  = 0;
    int  fe_wide  = 0;
    int  both_cnt = 0;
    logic rp_prev = 1'b0;
    logic fe_prev = 1'b0;
    logic busy_seen = 1'b0;

    param_writer #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .serial_in      (serial_in),
        .time_param_sel (time_param_sel),
        .time_value     (time_value),
        .reprogram      (reprogram),
        .frame_error    (frame_error),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (reprogram && !rp_prev) rp_cnt++;
        if (reprogram && rp_prev) rp_wide++;
        if (frame_error && !fe_prev) fe_cnt++;
        if (frame_error && fe_prev) fe_wide++;
        if (reprogram && frame_error) both_cnt++;
        if (busy) busy_seen = 1'b1;
        rp_prev = reprogram;
        fe_prev = frame_error;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic drive_bit(input logic b);
        serial_in = b;
        wait_clks(CPB);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_b);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef PARAM_WRITER_PARITY_EN
        drive_bit(^b);
`endif
        drive_bit(stop_b);
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        serial_in = 1'b1;
        wait_clks(3);
        n_checks++;
        if ({time_param_sel, time_value, reprogram, frame_error, busy} !== 9'd0)
            $display("FAIL reset_outputs got=%b want=%b",
                     {time_param_sel, time_value, reprogram, frame_error, busy}, 9'd0);
        else n_pass++;
        reset = 1'b0;
        wait_clks(5);
    endtask

    task automatic test_write_accept;
        int rp0, fe0;
        rp0 = rp_cnt; fe0 = fe_cnt;
        send_frame(8'h9A, 1'b1);
        wait_clks(10);
        n_checks++;
        if (rp_cnt - rp0 !== 1) $display("FAIL accept_9a_reprogram got=%0d want=1", rp_cnt - rp0);
        else n_pass++;
        n_checks++;
        if (fe_cnt - fe0 !== 0) $display("FAIL accept_9a_frame_error got=%0d want=0", fe_cnt - fe0);
        else n_pass++;
        n_checks++;
        if (time_param_sel !== 2'b01) $display("FAIL accept_9a_sel got=%b want=01", time_param_sel);
        else n_pass++;
        n_checks++;
        if (time_value !== 4'hA) $display("FAIL accept_9a_value got=%h want=a", time_value);
        else n_pass++;
    endtask

    task automatic test_bad_command;
        int rp0, fe0;
        rp0 = rp_cnt; fe0 = fe_cnt;
        send_frame(8'h5A, 1'b1);
        wait_clks(10);
        n_checks++;
        if (fe_cnt - fe0 !== 1) $display("FAIL badcmd_frame_error got=%0d want=1", fe_cnt - fe0);
        else n_pass++;
        n_checks++;
        if (rp_cnt - rp0 !== 0) $display("FAIL badcmd_reprogram got=%0d want=0", rp_cnt - rp0);
        else n_pass++;
        n_checks++;
        if ({time_param_sel, time_value} !== {2'b01, 4'hA})
            $display("FAIL badcmd_hold got=%b want=%b", {time_param_sel, time_value}, {2'b01, 4'hA});
        else n_pass++;
    endtask

    task automatic test_stop_low;
        int rp0, fe0;
        rp0 = rp_cnt; fe0 = fe_cnt;
        send_frame(8'hB3, 1'b0);
        serial_in = 1'b0;
        wait_clks(40);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL stoplow_no_retrigger busy=%b want=0", busy);
        else n_pass++;
        serial_in = 1'b1;
        wait_clks(20);
        n_checks++;
        if (fe_cnt - fe0 !== 1) $display("FAIL stoplow_frame_error got=%0d want=1", fe_cnt - fe0);
        else n_pass++;
        n_checks++;
        if (rp_cnt - rp0 !== 0) $display("FAIL stoplow_reprogram got=%0d want=0", rp_cnt - rp0);
        else n_pass++;
        n_checks++;
        if ({time_param_sel, time_value} !== {2'b01, 4'hA})
            $display("FAIL stoplow_hold got=%b want=%b", {time_param_sel, time_value}, {2'b01, 4'hA});
        else n_pass++;
    endtask

    task automatic test_glitch;
        int rp0, fe0;
        rp0 = rp_cnt; fe0 = fe_cnt;
        busy_seen = 1'b0;
        serial_in = 1'b0;
        wait_clks(4);
        serial_in = 1'b1;
        wait_clks(30);
        n_checks++;
        if (busy_seen !== 1'b1) $display("FAIL glitch_busy_pulse got=%b want=1", busy_seen);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL glitch_back_idle busy=%b want=0", busy);
        else n_pass++;
        n_checks++;
        if ((rp_cnt - rp0) + (fe_cnt - fe0) !== 0)
            $display("FAIL glitch_no_pulse got=%0d want=0", (rp_cnt - rp0) + (fe_cnt - fe0));
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int rp0, fe0;
        rp0 = rp_cnt; fe0 = fe_cnt;
        send_frame(8'hB5, 1'b1);
        n_checks++;
        if ({time_param_sel, time_value} !== {2'b11, 4'h5})
            $display("FAIL b2b_first got=%b want=%b", {time_param_sel, time_value}, {2'b11, 4'h5});
        else n_pass++;
        send_frame(8'h80, 1'b1);
        wait_clks(10);
        n_checks++;
        if (rp_cnt - rp0 !== 2) $display("FAIL b2b_reprogram got=%0d want=2", rp_cnt - rp0);
        else n_pass++;
        n_checks++;
        if (fe_cnt - fe0 !== 0) $display("FAIL b2b_frame_error got=%0d want=0", fe_cnt - fe0);
        else n_pass++;
        n_checks++;
        if ({time_param_sel, time_value} !== {2'b00, 4'h0})
            $display("FAIL b2b_zero_value got=%b want=%b", {time_param_sel, time_value}, 6'd0);
        else n_pass++;
    endtask

    task automatic test_mid_frame_reset;
        int rp0, fe0;
        logic [7:0] b;
        // Restore a non-zero output so the reset clearing is observable.
        send_frame(8'h9A, 1'b1);
        wait_clks(5);
        rp0 = rp_cnt; fe0 = fe_cnt;
        b = 8'h9A;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        serial_in = b[4];
        wait_clks(8);
        reset = 1'b1;
        #1;
        n_checks++;
        if ({time_param_sel, time_value, reprogram, frame_error, busy} !== 9'd0)
            $display("FAIL midreset_outputs got=%b want=%b",
                     {time_param_sel, time_value, reprogram, frame_error, busy}, 9'd0);
        else n_pass++;
        serial_in = 1'b1;
        wait_clks(5);
        reset = 1'b0;
        wait_clks(20);
        n_checks++;
        if ((rp_cnt - rp0) + (fe_cnt - fe0) !== 0)
            $display("FAIL midreset_no_pulse got=%0d want=0", (rp_cnt - rp0) + (fe_cnt - fe0));
        else n_pass++;
        send_frame(8'hAF, 1'b1);
        wait_clks(10);
        n_checks++;
        if (rp_cnt - rp0 !== 1) $display("FAIL after_reset_reprogram got=%0d want=1", rp_cnt - rp0);
        else n_pass++;
        n_checks++;
        if ({time_param_sel, time_value} !== {2'b10, 4'hF})
            $display("FAIL after_reset_af got=%b want=%b", {time_param_sel, time_value}, {2'b10, 4'hF});
        else n_pass++;
    endtask

`ifdef PARAM_WRITER_PARITY_EN
    task automatic send_frame_par(input logic [7:0] b, input logic par_b);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(par_b);
        drive_bit(1'b1);
    endtask

    task automatic test_parity;
        int rp0, fe0;
        rp0 = rp_cnt; fe0 = fe_cnt;
        send_frame_par(8'h9A, 1'b0);
        wait_clks(10);
        n_checks++;
        if (rp_cnt - rp0 !== 1) $display("FAIL parity_good_reprogram got=%0d want=1", rp_cnt - rp0);
        else n_pass++;
        send_frame_par(8'h9A, 1'b1);
        wait_clks(10);
        n_checks++;
        if (fe_cnt - fe0 !== 1) $display("FAIL parity_bad_frame_error got=%0d want=1", fe_cnt - fe0);
        else n_pass++;
        n_checks++;
        if (rp_cnt - rp0 !== 1) $display("FAIL parity_bad_reprogram got=%0d want=1", rp_cnt - rp0);
        else n_pass++;
    endtask
`endif

    task automatic test_pulse_shape;
        n_checks++;
        if (both_cnt !== 0) $display("FAIL overlap_cycles got=%0d want=0", both_cnt);
        else n_pass++;
        n_checks++;
        if (rp_wide !== 0) $display("FAIL reprogram_width_extra got=%0d want=0", rp_wide);
        else n_pass++;
        n_checks++;
        if (fe_wide !== 0) $display("FAIL frame_error_width_extra got=%0d want=0", fe_wide);
        else n_pass++;
    endtask

    initial begin
        reset     = 1'b1;
        serial_in = 1'b1;
        test_reset();
        test_write_accept();
        test_bad_command();
        test_stop_low();
        test_glitch();
        test_back_to_back();
        test_mid_frame_reset();
`ifdef PARAM_WRITER_PARITY_EN
        test_parity();
`endif
        test_pulse_shape();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
